// File: rtl/axis_slave_sink.sv
`timescale 1ns/1ps
// axis_slave_sink: AXI4-Stream slave endpoint.
// Accepts beats into a first-word-fall-through buffer read by a local consumer.
// Throttles s_tready with a rotating backpressure pattern.
// Counts beats and packets, and raises sticky flags for null beats and
// mid-packet tid/tdest changes.
module axis_slave_sink #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEST_WIDTH    = 4,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [31:0] READY_PATTERN = 32'hFFFF_FFFF
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_tstrb,
    input  logic [DATA_WIDTH/8-1:0]       s_tkeep,
    input  logic                          s_tlast,
    input  logic                          s_tid,
    input  logic [DEST_WIDTH-1:0]         s_tdest,
    input  logic [USER_WIDTH-1:0]         s_tuser,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_tdata,
    output logic [DATA_WIDTH/8-1:0]       rd_tkeep,
    output logic                          rd_tlast,
    output logic [DEST_WIDTH-1:0]         rd_tdest,
    output logic [USER_WIDTH-1:0]         rd_tuser,
    input  logic                          bp_en,
    input  logic                          err_clr,
    output logic [31:0]                   beat_count,
    output logic [31:0]                   pkt_count,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          err_null_beat,
    output logic                          err_dest_change
);

    localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_W + 1 + DEST_WIDTH + USER_WIDTH;
    localparam logic [AW:0] DEPTH_VAL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_e;

    state_e                stateQ, stateD;
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [AW:0]           count_q, count_d;
    logic [31:0]           pat_q, pat_d;
    logic [31:0]           beatCount_q, beatCount_d;
    logic [31:0]           pktCount_q, pktCount_d;
    logic                  tid_q, tid_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                  errNull_q, errNull_d;
    logic                  errDest_q, errDest_d;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    headEntry;

    logic                  push;
    logic                  pop;
    logic                  nullEvt;
    logic                  destEvt;

    // tstrb is deliberately neither applied nor stored; it is folded here only
    // so the port is visibly consumed.
    logic                  unusedStrb;
    assign unusedStrb = ^s_tstrb;

    // Ready only depends on buffer space and the current pattern bit, never on
    // s_tvalid, so a full buffer blocks the source with no pass-through.
    assign s_tready = (count_q != DEPTH_VAL) && (pat_q[0] || !bp_en);
    assign rd_valid = (count_q != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = rd_en && rd_valid;

    assign nullEvt  = push && (s_tkeep == '0) && !s_tlast;
    assign destEvt  = push && (stateQ == IN_PKT) &&
                      ((s_tid != tid_q) || (s_tdest != tdest_q));

    assign headEntry = mem_q[rdPtr_q];
    assign {rd_tdata, rd_tkeep, rd_tlast, rd_tdest, rd_tuser} = headEntry;

    assign beat_count      = beatCount_q;
    assign pkt_count       = pktCount_q;
    assign fill_level      = count_q;
    assign err_null_beat   = errNull_q;
    assign err_dest_change = errDest_q;

    // Packet FSM next state: a non-last beat in IDLE opens a packet, a last
    // beat inside a packet closes it; idle cycles hold the state.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (push && !s_tlast) begin
                    stateD = IN_PKT;
                end
            end
            IN_PKT: begin
                if (push && s_tlast) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Datapath next state: pointers, occupancy, pattern rotation, counters,
    // packet header latch and sticky flags (a new event beats err_clr).
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        pat_d       = pat_q;
        beatCount_d = beatCount_q;
        pktCount_d  = pktCount_q;
        tid_d       = tid_q;
        tdest_d     = tdest_q;
        errNull_d   = (errNull_q & ~err_clr) | nullEvt;
        errDest_d   = (errDest_q & ~err_clr) | destEvt;

        if (bp_en) begin
            pat_d = {pat_q[0], pat_q[31:1]};
        end

        if (push) begin
            wrPtr_d     = wrPtr_q + AW'(1);
            beatCount_d = beatCount_q + 32'd1;
            if (s_tlast) begin
                pktCount_d = pktCount_q + 32'd1;
            end
            if ((stateQ == IDLE) && !s_tlast) begin
                tid_d   = s_tid;
                tdest_d = s_tdest;
            end
        end

        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stateQ      <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            pat_q       <= READY_PATTERN;
            beatCount_q <= '0;
            pktCount_q  <= '0;
            tid_q       <= 1'b0;
            tdest_q     <= '0;
            errNull_q   <= 1'b0;
            errDest_q   <= 1'b0;
        end else begin
            stateQ      <= stateD;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            pat_q       <= pat_d;
            beatCount_q <= beatCount_d;
            pktCount_q  <= pktCount_d;
            tid_q       <= tid_d;
            tdest_q     <= tdest_d;
            errNull_q   <= errNull_d;
            errDest_q   <= errDest_d;
        end
    end

    // Beat storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {s_tdata, s_tkeep, s_tlast, s_tdest, s_tuser};
        end
    end

endmodule

// File: doc/axis_slave_sink.md
AXIS_SLAVE_SINK -- requirements
Module: axis_slave_sink

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, tdata width in bits; multiple of 8.
- DEST_WIDTH, 4, tdest width.
- USER_WIDTH, 1, tuser width.
- FIFO_DEPTH, 8, beat buffer depth; power of 2, minimum 2.
- READY_PATTERN, 32'hFFFF_FFFF, backpressure mask; bit 0 is applied first.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. The block has one clock. Reset is asynchronous and active-low.
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_tvalid, in, 1, AXIS valid.
- s_tready, out, 1, AXIS ready.
- s_tdata, in, DATA_WIDTH, payload.
- s_tstrb, in, DATA_WIDTH/8, byte strobes.
- s_tkeep, in, DATA_WIDTH/8, byte keeps.
- s_tlast, in, 1, packet end.
- s_tid, in, 1, stream ID.
- s_tdest, in, DEST_WIDTH, routing.
- s_tuser, in, USER_WIDTH, sideband.
- rd_en, in, 1, pop request from the local consumer.
- rd_valid, out, 1, buffer not empty.
- rd_tdata, rd_tkeep, rd_tlast, rd_tdest, rd_tuser, out, matching widths, head beat fields.
- bp_en, in, 1, enables READY_PATTERN throttling; when 0 the pattern is treated as all ones.
- err_clr, in, 1, clears the sticky error flags.
- beat_count, out, 32, number of accepted beats.
- pkt_count, out, 32, number of accepted tlast beats.
- fill_level, out, $clog2(FIFO_DEPTH)+1, current buffer occupancy.
- err_null_beat, out, 1, sticky flag.
- err_dest_change, out, 1, sticky flag.

Function
REQ-003 A beat SHALL be accepted on a rising aclk edge exactly when s_tvalid and s_tready are both 1.
REQ-004 s_tready SHALL be combinational and equal to (fill_level != FIFO_DEPTH) AND (pat[0] OR NOT bp_en), where pat is a 32-bit register loaded with READY_PATTERN.
REQ-005 When bp_en is 1, pat SHALL rotate right by 1 bit every cycle, independent of s_tvalid.
REQ-006 s_tready SHALL NOT depend on s_tvalid.
REQ-007 The buffer SHALL store tdata, tkeep, tlast, tdest and tuser for each accepted beat.
REQ-008 The buffer SHALL be first-word-fall-through: rd_* outputs SHALL show the head beat while rd_valid is 1.
REQ-009 A pop SHALL occur when rd_en AND rd_valid; rd_en while empty SHALL be ignored.
REQ-010 A simultaneous push and pop SHALL leave fill_level unchanged.
REQ-011 At full, s_tready is 0, so there is no same-cycle pass-through; a pop at full SHALL raise s_tready in the next cycle.
REQ-012 Write and read pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 Write-to-rd_valid latency SHALL be 1 cycle: a beat accepted at edge N is visible after edge N.
REQ-014 The packet FSM SHALL have two states, IDLE and IN_PKT, with these transitions:
- IDLE, accepted beat with tlast=0: latch tid/tdest, go to IN_PKT.
- IDLE, accepted beat with tlast=1: single-beat packet, stay in IDLE.
- IN_PKT, accepted beat with tlast=1: go to IDLE.
- No accepted beat: state holds.
REQ-015 In IN_PKT, an accepted beat whose tid or tdest differs from the latched values SHALL set err_dest_change.
REQ-016 An accepted beat with s_tkeep all-zero and tlast=0 SHALL set err_null_beat.
REQ-017 Sticky error flags SHALL clear on err_clr. If err_clr coincides with a new error event, the flag SHALL end set (set wins).
REQ-018 beat_count SHALL increment on every accepted beat; pkt_count SHALL increment on every accepted beat with tlast=1.
REQ-019 beat_count and pkt_count SHALL wrap from 2^32-1 to 0 without flagging.
REQ-020 The block SHALL NOT apply tstrb to stored data and SHALL NOT store tstrb.

Reset
REQ-021 On aresetn=0, the following SHALL reset asynchronously, with deassertion synchronous to aclk:
- pointers, fill_level, beat_count, pkt_count, and both error flags to 0.
- FSM to IDLE.
- pat to READY_PATTERN.
- rd_valid to 0; s_tready follows REQ-004, giving 1 when bp_en=0 or READY_PATTERN[0]=1.
REQ-022 Reset asserted mid-packet SHALL discard all buffered beats. The first beat accepted after reset SHALL be treated as a packet start.
REQ-023 Buffer storage contents need not be reset; rd_tdata is don't-care while rd_valid is 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single beat: tdata=32'hABCD, tkeep=4'hF, tlast=1, rd_en=0 -> rd_valid=1 next cycle, rd_tdata=32'hABCD, beat_count=1, pkt_count=1, FSM in IDLE.
- Fill: 9 back-to-back beats with DEPTH=8 and rd_en=0 -> s_tready=0 after the 8th beat, fill_level=8, the 9th beat is held by the source; one pop -> 9th beat accepted the next cycle.
- Backpressure: bp_en=1 with READY_PATTERN=32'h5555_5555 and continuous tvalid -> s_tready alternates 1,0,1,0 and beats are accepted every other cycle.
- Dest change: 3-beat packet with tdest 2,2,5 -> err_dest_change=1 after the 3rd beat, pkt_count=1; err_clr -> flag 0.
- Null beat: tkeep=0, tlast=0 -> err_null_beat=1; the beat is still stored and counted.
- Reset mid-packet: 2 beats with tlast=0, then aresetn low -> fill_level=0, counts 0; next beat with tlast=1 -> pkt_count=1 and no errors.
